// File: rtl/ahb_arbiter_if.sv
// Arbitration bus bundle: request/transfer signals from the masters, grant/owner back.
interface ahb_arbiter_if #(
   parameter int MASTER_NUM = 4,
   parameter int MW         = 2
);
   logic [MASTER_NUM-1:0] hbusreq;
   logic [MASTER_NUM-1:0] hlock;
   logic [1:0]            htrans;
   logic [2:0]            hburst;
   logic                  hready;
   logic [MASTER_NUM-1:0] hgrant;
   logic [MW-1:0]         hmaster;
   logic                  hmastlock;

   modport master (
      output hbusreq, hlock, htrans, hburst, hready,
      input  hgrant, hmaster, hmastlock
   );

   modport slave (
      input  hbusreq, hlock, htrans, hburst, hready,
      output hgrant, hmaster, hmastlock
   );
endinterface

// File: rtl/ahb_arbiter.sv
// Round-robin AHB arbiter: holds grant across fixed bursts and locked sequences,
// publishes the address-phase owner one accepted transfer after the grant.
module ahb_arbiter #(
   parameter int MASTER_NUM     = 4,
   parameter int MW             = 2,
   parameter int DEFAULT_MASTER = 0
) (
   input logic          hclk,
   input logic          hresetn,
   ahb_arbiter_if.slave bus
);
   localparam logic [1:0] TRANS_IDLE   = 2'd0;
   localparam logic [1:0] TRANS_BUSY   = 2'd1;
   localparam logic [1:0] TRANS_NONSEQ = 2'd2;
   localparam logic [1:0] TRANS_SEQ    = 2'd3;

   logic [MW-1:0]         owner_reg;
   logic [MW-1:0]         hmaster_reg;
   logic                  hmastlock_reg;
   logic [4:0]            beat_cnt_reg;
   logic [4:0]            beat_cnt_next;
   logic [MW-1:0]         owner_next;
   logic [MW:0]           scan_idx;
   logic                  scan_found;
   logic                  hold_lock;
   logic                  rearb;
   logic [MASTER_NUM-1:0] grant;

   // Remaining beats after this cycle; wait states and BUSY leave the count alone.
   always_comb begin
      beat_cnt_next = beat_cnt_reg;
      if (bus.hready) begin
         case (bus.htrans)
            TRANS_NONSEQ: begin
               case (bus.hburst)
                  3'd2, 3'd3: beat_cnt_next = 5'd3;
                  3'd4, 3'd5: beat_cnt_next = 5'd7;
                  3'd6, 3'd7: beat_cnt_next = 5'd15;
                  default:    beat_cnt_next = 5'd0;
               endcase
            end
            TRANS_SEQ: begin
               if (beat_cnt_reg != 5'd0)
                  beat_cnt_next = beat_cnt_reg - 5'd1;
            end
            TRANS_BUSY: beat_cnt_next = beat_cnt_reg;
            TRANS_IDLE: beat_cnt_next = 5'd0;
            default:    beat_cnt_next = beat_cnt_reg;
         endcase
      end
   end

   assign hold_lock = bus.hlock[owner_reg] & bus.hbusreq[owner_reg];
   assign rearb     = bus.hready & (beat_cnt_next <= 5'd1) & ~hold_lock;

   // Scan starts just after the current owner and visits the owner last.
   always_comb begin
      owner_next = MW'(DEFAULT_MASTER);
      scan_found = 1'b0;
      scan_idx   = '0;
      for (int k = 1; k <= MASTER_NUM; k++) begin
         scan_idx = {1'b0, owner_reg} + (MW+1)'(k);
         if (scan_idx >= (MW+1)'(MASTER_NUM))
            scan_idx = scan_idx - (MW+1)'(MASTER_NUM);
         if (!scan_found && bus.hbusreq[scan_idx[MW-1:0]]) begin
            owner_next = scan_idx[MW-1:0];
            scan_found = 1'b1;
         end
      end
   end

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         owner_reg     <= MW'(DEFAULT_MASTER);
         hmaster_reg   <= MW'(DEFAULT_MASTER);
         hmastlock_reg <= 1'b0;
         beat_cnt_reg  <= 5'd0;
      end else begin
         beat_cnt_reg <= beat_cnt_next;
         if (rearb)
            owner_reg <= owner_next;
         if (bus.hready) begin
            hmaster_reg   <= owner_reg;
            hmastlock_reg <= bus.hlock[owner_reg];
         end
      end
   end

   for (genvar gi = 0; gi < MASTER_NUM; gi++) begin : g_grant
      assign grant[gi] = (owner_reg == MW'(gi));
   end

   assign bus.hgrant    = grant;
   assign bus.hmaster   = hmaster_reg;
   assign bus.hmastlock = hmastlock_reg;
endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed bench for ahb_arbiter: expected grant/owner/lock queued per step, checked after each edge.
module tb_ahb_arbiter;
   localparam logic [1:0] T_IDLE   = 2'd0;
   localparam logic [1:0] T_BUSY   = 2'd1;
   localparam logic [1:0] T_NONSEQ = 2'd2;
   localparam logic [1:0] T_SEQ    = 2'd3;

   typedef struct {
      string      tag;
      logic [3:0] grant;
      logic [1:0] master;
      logic       lock;
   } exp_t;

   logic hclk;
   logic hresetn;
   int   n_cmp = 0;
   int   n_mis = 0;
   exp_t sb[$];

   ahb_arbiter_if #(.MASTER_NUM(4), .MW(2)) bus ();

   ahb_arbiter #(.MASTER_NUM(4), .MW(2), .DEFAULT_MASTER(0)) dut (
      .hclk    (hclk),
      .hresetn (hresetn),
      .bus     (bus)
   );

   initial hclk = 1'b0;
   always #5 hclk = ~hclk;

   task automatic cmp(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_mis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_front();
      exp_t e;
      e = sb.pop_front();
      cmp({e.tag, ".hgrant"},    16'(bus.hgrant),    16'(e.grant));
      cmp({e.tag, ".hmaster"},   16'(bus.hmaster),   16'(e.master));
      cmp({e.tag, ".hmastlock"}, 16'(bus.hmastlock), 16'(e.lock));
      $display("step %-12s grant=%b hmaster=%0d hmastlock=%b", e.tag, bus.hgrant, bus.hmaster, bus.hmastlock);
   endtask

   task automatic expect_now(input string tag, input logic [3:0] eg, input logic [1:0] em, input logic el);
      sb.push_back('{tag, eg, em, el});
      check_front();
   endtask

   task automatic step(input string tag, input logic [3:0] req, input logic [3:0] lck,
                       input logic [1:0] tr, input logic [2:0] bu, input logic rdy,
                       input logic [3:0] eg, input logic [1:0] em, input logic el);
      bus.hbusreq = req;
      bus.hlock   = lck;
      bus.htrans  = tr;
      bus.hburst  = bu;
      bus.hready  = rdy;
      sb.push_back('{tag, eg, em, el});
      @(posedge hclk);
      #1;
      check_front();
   endtask

   initial begin
      hresetn     = 1'b0;
      bus.hbusreq = 4'b1111;
      bus.hlock   = 4'b0000;
      bus.htrans  = T_IDLE;
      bus.hburst  = 3'd0;
      bus.hready  = 1'b1;
      repeat (3) @(posedge hclk);
      #1;
      expect_now("rst_hold", 4'b0001, 2'd0, 1'b0);
      hresetn = 1'b1;

      // Rotation with everyone requesting
      step("rot1", 4'b1111, 4'b0000, T_IDLE, 3'd0, 1'b1, 4'b0010, 2'd0, 1'b0);
      step("rot2", 4'b1111, 4'b0000, T_IDLE, 3'd0, 1'b1, 4'b0100, 2'd1, 1'b0);
      step("rot3", 4'b1111, 4'b0000, T_IDLE, 3'd0, 1'b1, 4'b1000, 2'd2, 1'b0);
      step("rot4", 4'b1111, 4'b0000, T_IDLE, 3'd0, 1'b1, 4'b0001, 2'd3, 1'b0);
      step("rot5", 4'b1111, 4'b0000, T_IDLE, 3'd0, 1'b1, 4'b0010, 2'd0, 1'b0);
      step("rot6", 4'b1111, 4'b0000, T_IDLE, 3'd0, 1'b1, 4'b0100, 2'd1, 1'b0);

      // No requests from owner 2 -> default master
      step("dflt1", 4'b0000, 4'b0000, T_IDLE, 3'd0, 1'b1, 4'b0001, 2'd2, 1'b0);
      step("dflt2", 4'b0000, 4'b0000, T_IDLE, 3'd0, 1'b1, 4'b0001, 2'd0, 1'b0);

      // INCR4 by master 1 while master 3 waits
      step("i4_gnt", 4'b0010, 4'b0000, T_IDLE,   3'd0, 1'b1, 4'b0010, 2'd0, 1'b0);
      step("i4_own", 4'b0010, 4'b0000, T_IDLE,   3'd0, 1'b1, 4'b0010, 2'd1, 1'b0);
      step("i4_b1",  4'b1010, 4'b0000, T_NONSEQ, 3'd3, 1'b1, 4'b0010, 2'd1, 1'b0);
      step("i4_b2",  4'b1010, 4'b0000, T_SEQ,    3'd3, 1'b1, 4'b0010, 2'd1, 1'b0);
      step("i4_b3",  4'b1000, 4'b0000, T_SEQ,    3'd3, 1'b1, 4'b1000, 2'd1, 1'b0);
      step("i4_b4",  4'b1000, 4'b0000, T_SEQ,    3'd3, 1'b1, 4'b1000, 2'd3, 1'b0);

      // Same INCR4 with two wait states and a BUSY
      step("w_gnt",  4'b0010, 4'b0000, T_IDLE,   3'd0, 1'b1, 4'b0010, 2'd3, 1'b0);
      step("w_own",  4'b0010, 4'b0000, T_IDLE,   3'd0, 1'b1, 4'b0010, 2'd1, 1'b0);
      step("w_b1",   4'b1010, 4'b0000, T_NONSEQ, 3'd3, 1'b1, 4'b0010, 2'd1, 1'b0);
      step("w_ws1",  4'b1010, 4'b0000, T_SEQ,    3'd3, 1'b0, 4'b0010, 2'd1, 1'b0);
      step("w_ws2",  4'b1010, 4'b0000, T_SEQ,    3'd3, 1'b0, 4'b0010, 2'd1, 1'b0);
      step("w_b2",   4'b1010, 4'b0000, T_SEQ,    3'd3, 1'b1, 4'b0010, 2'd1, 1'b0);
      step("w_busy", 4'b1010, 4'b0000, T_BUSY,   3'd3, 1'b1, 4'b0010, 2'd1, 1'b0);
      step("w_b3",   4'b1000, 4'b0000, T_SEQ,    3'd3, 1'b1, 4'b1000, 2'd1, 1'b0);
      step("w_b4",   4'b1000, 4'b0000, T_SEQ,    3'd3, 1'b1, 4'b1000, 2'd3, 1'b0);

      // Locked sequence by master 2 with master 0 requesting
      step("lk_gnt", 4'b0100, 4'b0100, T_IDLE,   3'd0, 1'b1, 4'b0100, 2'd3, 1'b0);
      for (int i = 0; i < 5; i++)
         step($sformatf("lk_hold%0d", i), 4'b0101, 4'b0100, T_NONSEQ, 3'd0, 1'b1, 4'b0100, 2'd2, 1'b1);
      step("lk_drop", 4'b0101, 4'b0000, T_NONSEQ, 3'd0, 1'b1, 4'b0001, 2'd2, 1'b0);

      // INCR8 from master 0 aborted by IDLE after two beats
      step("et_own", 4'b0001, 4'b0000, T_IDLE,   3'd0, 1'b1, 4'b0001, 2'd0, 1'b0);
      step("et_b1",  4'b0011, 4'b0000, T_NONSEQ, 3'd5, 1'b1, 4'b0001, 2'd0, 1'b0);
      step("et_b2",  4'b0011, 4'b0000, T_SEQ,    3'd5, 1'b1, 4'b0001, 2'd0, 1'b0);
      step("et_idle", 4'b0011, 4'b0000, T_IDLE,  3'd5, 1'b1, 4'b0010, 2'd0, 1'b0);
      cmp("et_cnt", 16'(dut.beat_cnt_reg), 16'd0);

      // Reset in the middle of an INCR16 from master 1
      step("r16_own", 4'b0010, 4'b0000, T_IDLE,   3'd0, 1'b1, 4'b0010, 2'd1, 1'b0);
      step("r16_b1",  4'b0011, 4'b0000, T_NONSEQ, 3'd7, 1'b1, 4'b0010, 2'd1, 1'b0);
      step("r16_b2",  4'b0011, 4'b0000, T_SEQ,    3'd7, 1'b1, 4'b0010, 2'd1, 1'b0);
      cmp("r16_cnt", 16'(dut.beat_cnt_reg), 16'd14);
      #2 hresetn = 1'b0;
      #1;
      expect_now("rst_async", 4'b0001, 2'd0, 1'b0);
      cmp("rst_cnt", 16'(dut.beat_cnt_reg), 16'd0);
      @(posedge hclk);
      #1 hresetn = 1'b1;
      cmp("rel_cnt", 16'(dut.beat_cnt_reg), 16'd0);
      // A stale count would block this rearbitration
      step("post_rst", 4'b0010, 4'b0000, T_SEQ, 3'd7, 1'b1, 4'b0010, 2'd0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
